// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode encodings, bundle width, skid states.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Decoded bundle minus the immediate:
  // rd_e,rd,rs1_e,rs1,rs2_e,rs2 (18) + imm_e,pc_e,jump_e,branch_e,illegal (5) + full_inst (17).
  // Bundle width is BUNDLE_CTRL_W + XLEN.
  localparam int unsigned BUNDLE_CTRL_W = 40;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/decoder_comb.sv
// Combinational RV32I field extraction and illegal-instruction check.
// Bundle layout (MSB first): rd_e, rd, rs1_e, rs1, rs2_e, rs2, imm_e, pc_e,
// jump_e, branch_e, illegal, full_inst[16:0], imm[XLEN-1:0].
module decoder_comb
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          CHK_FUNCT = 1'b1
) (
  input  logic [31:0]                   inst,
  output logic [BUNDLE_CTRL_W+XLEN-1:0] bundle
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opcode = inst[6:0];
  assign rd_f   = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic            rd_e, rs1_e, rs2_e, imm_e, pc_e, jump_e, branch_e;
  logic            known, bad_funct, illegal, keep_f3, keep_f7;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] imm;
  logic [16:0]     full;

  // Per-format enables, immediate select and funct legality.
  always_comb begin
    rd_e      = 1'b0;
    rs1_e     = 1'b0;
    rs2_e     = 1'b0;
    imm_e     = 1'b0;
    pc_e      = 1'b0;
    jump_e    = 1'b0;
    branch_e  = 1'b0;
    known     = 1'b1;
    bad_funct = 1'b0;
    keep_f3   = 1'b0;
    keep_f7   = 1'b0;
    rs1_idx   = rs1_f;
    imm       = '0;
    case (opcode)
      OP_R: begin
        rd_e = 1'b1; rs1_e = 1'b1; rs2_e = 1'b1;
        keep_f3 = 1'b1; keep_f7 = 1'b1;
        if (CHK_FUNCT) begin
          if (funct7 == 7'b0100000)
            bad_funct = (funct3 != 3'b000) && (funct3 != 3'b101);
          else
            bad_funct = (funct7 != 7'b0000000);
        end
      end
      OP_IMM, OP_LOAD, OP_SYS, OP_FENCE, OP_JALR: begin
        rd_e = 1'b1; rs1_e = 1'b1; imm_e = 1'b1; keep_f3 = 1'b1;
        imm = imm_i;
        if (opcode == OP_JALR) begin
          jump_e = 1'b1;
          bad_funct = CHK_FUNCT && (funct3 != 3'b000);
        end
      end
      OP_STORE: begin
        rs1_e = 1'b1; rs2_e = 1'b1; imm_e = 1'b1; keep_f3 = 1'b1;
        imm = imm_s;
      end
      OP_BRANCH: begin
        rs1_e = 1'b1; rs2_e = 1'b1; imm_e = 1'b1; pc_e = 1'b1; branch_e = 1'b1;
        keep_f3 = 1'b1;
        imm = imm_b;
      end
      OP_LUI: begin
        rd_e = 1'b1; rs1_e = 1'b1; rs1_idx = 5'd0; imm_e = 1'b1;
        imm = imm_u;
      end
      OP_AUIPC: begin
        rd_e = 1'b1; pc_e = 1'b1; imm_e = 1'b1;
        imm = imm_u;
      end
      OP_JAL: begin
        rd_e = 1'b1; pc_e = 1'b1; jump_e = 1'b1; imm_e = 1'b1;
        imm = imm_j;
      end
      default: known = 1'b0;
    endcase
  end

  // Pack the bundle; an illegal instruction reports only its illegal flag.
  always_comb begin
    illegal = ~known | bad_funct | (inst[1:0] != 2'b11);
    full    = {keep_f7 ? funct7 : 7'b0, keep_f3 ? funct3 : 3'b0, opcode};
    if (illegal) begin
      bundle            = '0;
      bundle[XLEN + 17] = 1'b1;
    end else begin
      bundle = {rd_e & (rd_f != 5'd0), rd_f, rs1_e, rs1_idx, rs2_e, rs2_f,
                imm_e, pc_e, jump_e, branch_e, 1'b0, full, imm};
    end
  end

endmodule

// File: rtl/decoder_stage.sv
// Registered RV32I decode stage with valid/ready handshake and 2-entry skid buffer.
module decoder_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          SKID_EN   = 1'b1,
  parameter bit          CHK_FUNCT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            rd_e,
  output logic [4:0]      rd,
  output logic            rs1_e,
  output logic [4:0]      rs1,
  output logic            rs2_e,
  output logic [4:0]      rs2,
  output logic            imm_e,
  output logic [XLEN-1:0] imm,
  output logic            pc_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            illegal,
  output logic [16:0]     full_inst
);

  localparam int unsigned BW = BUNDLE_CTRL_W + XLEN;

  logic [BW-1:0]   dec_bundle, out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  skid_state_e     state_q, state_d;
  logic            in_ready_q;
  logic            in_fire, out_fire, load_out, load_skid, promote;

  decoder_comb #(
    .XLEN      (XLEN),
    .CHK_FUNCT (CHK_FUNCT)
  ) u_decoder_comb (
    .inst   (in_inst),
    .bundle (dec_bundle)
  );

  // Without the skid slot the stage is a plain pipeline register, so FULL is unreachable.
  assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~out_valid);
  assign out_valid = (state_q != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  // Skid occupancy transitions; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          load_out = 1'b1;
          state_d  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = SKID_FULL;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          promote = 1'b1;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d   = SKID_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      promote   = 1'b0;
    end
  end

  // Occupancy state and registered in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_pc_q  <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      if (load_out) begin
        out_q    <= dec_bundle;
        out_pc_q <= in_pc;
      end else if (promote) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc_q;
      end
      if (load_skid) begin
        skid_q    <= dec_bundle;
        skid_pc_q <= in_pc;
      end
    end
  end

  assign {rd_e, rd, rs1_e, rs1, rs2_e, rs2, imm_e, pc_e, jump_e, branch_e,
          illegal, full_inst, imm} = out_q;
  assign out_pc = out_pc_q;

endmodule

// File: tb/tb_decoder_stage.sv
// Self-checking bench for decoder_stage: scoreboard of expected bundles plus directed tests.
module tb_decoder_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, imm;
  logic        rd_e, rs1_e, rs2_e, imm_e, pc_e, jump_e, branch_e, illegal;
  logic [4:0]  rd, rs1, rs2;
  logic [16:0] full_inst;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_out  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [71:0] bundle;
    logic [71:0] care;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [71:0] obs;

  assign obs = {rd_e, rd, rs1_e, rs1, rs2_e, rs2, imm_e, pc_e, jump_e, branch_e,
                illegal, full_inst, imm};

  always #5 clk = ~clk;

  decoder_stage #(
    .XLEN      (32),
    .SKID_EN   (1'b1),
    .CHK_FUNCT (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .rd_e      (rd_e),
    .rd        (rd),
    .rs1_e     (rs1_e),
    .rs1       (rs1),
    .rs2_e     (rs2_e),
    .rs2       (rs2),
    .imm_e     (imm_e),
    .imm       (imm),
    .pc_e      (pc_e),
    .jump_e    (jump_e),
    .branch_e  (branch_e),
    .illegal   (illegal),
    .full_inst (full_inst)
  );

  // Reference decode written from the instruction-format table.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  d, s1, s2;
    logic        has_rd, r1e, r2e, ime, pce, jme, bre, bad;
    logic [31:0] im;
    logic [16:0] fi;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    d = i[11:7]; s1 = i[19:15]; s2 = i[24:20];
    has_rd = 0; r1e = 0; r2e = 0; ime = 0; pce = 0; jme = 0; bre = 0; bad = 0;
    im = '0;
    fi = {7'b0, f3, op};
    case (op)
      7'h33: begin
        has_rd = 1; r1e = 1; r2e = 1; fi = {f7, f3, op};
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13, 7'h03, 7'h73, 7'h0f, 7'h67: begin
        has_rd = 1; r1e = 1; ime = 1;
        im = {{20{i[31]}}, i[31:20]};
        if (op == 7'h67) begin jme = 1; bad = (f3 != 3'd0); end
      end
      7'h23: begin
        r1e = 1; r2e = 1; ime = 1;
        im = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        r1e = 1; r2e = 1; ime = 1; pce = 1; bre = 1;
        im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37: begin
        has_rd = 1; r1e = 1; s1 = 5'd0; ime = 1;
        im = {i[31:12], 12'h000}; fi = {10'b0, op};
      end
      7'h17: begin
        has_rd = 1; pce = 1; ime = 1;
        im = {i[31:12], 12'h000}; fi = {10'b0, op};
      end
      7'h6f: begin
        has_rd = 1; pce = 1; jme = 1; ime = 1;
        im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; fi = {10'b0, op};
      end
      default: bad = 1;
    endcase
    if (bad) begin
      has_rd = 0; r1e = 0; r2e = 0; ime = 0; pce = 0; jme = 0; bre = 0;
      im = '0; fi = '0; d = '0; s1 = '0; s2 = '0;
    end
    e.pc     = pc;
    e.bundle = {has_rd && (d != 5'd0), d, r1e, s1, r2e, s2, ime, pce, jme, bre, bad, fi, im};
    e.care   = '1;
    if (!has_rd) e.care[70:66] = '0;
    if (!r1e)    e.care[64:60] = '0;
    if (!r2e)    e.care[58:54] = '0;
    return e;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h bundle=%h, required no output", out_pc, obs);
        end else begin
          mon_e = sb.pop_front();
          if (out_pc !== mon_e.pc || (obs & mon_e.care) !== (mon_e.bundle & mon_e.care)) begin
            errors++;
            $display("FAIL sb_bundle: got pc=%h bundle=%h, required pc=%h bundle=%h (care %h)",
                     out_pc, obs, mon_e.pc, mon_e.bundle, mon_e.care);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_decode(in_inst, in_pc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1);
  end

  // Offer one instruction; called on a negedge, returns on the negedge after acceptance.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    #2;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance (inst %h)", inst);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", out_valid);
    end
    checks++;
    if ({obs, out_pc} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h pc=%h, required all 0", obs, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_addi();
    @(negedge clk);
    out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    #2;
    checks++;
    if (out_valid !== 1 || rd_e !== 1 || rd !== 5'd1 || rs1 !== 5'd0 || imm_e !== 1 || imm !== 32'd5) begin
      errors++;
      $display("FAIL addi_fields: got v=%b rd_e=%b rd=%0d rs1=%0d imm_e=%b imm=%h, required 1 1 1 0 1 00000005",
               out_valid, rd_e, rd, rs1, imm_e, imm);
    end
    checks++;
    if (full_inst !== 17'h00013 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL addi_tag: got full_inst=%h pc=%h, required 00013 00000100", full_inst, out_pc);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    send(32'hFE208EE3, 32'h200);
    #2;
    checks++;
    if (branch_e !== 1 || pc_e !== 1 || rs1 !== 5'd1 || rs2 !== 5'd2 || imm !== 32'hFFFFFFFC || rd_e !== 0) begin
      errors++;
      $display("FAIL beq_fields: got br=%b pc_e=%b rs1=%0d rs2=%0d imm=%h rd_e=%b, required 1 1 1 2 fffffffc 0",
               branch_e, pc_e, rs1, rs2, imm, rd_e);
    end
  endtask

  task automatic test_jump();
    @(negedge clk);
    send(32'h0080006F, 32'h300);
    #2;
    checks++;
    if (jump_e !== 1 || imm !== 32'd8 || rd !== 5'd0 || rd_e !== 0) begin
      errors++;
      $display("FAIL jal_fields: got jump=%b imm=%h rd=%0d rd_e=%b, required 1 00000008 0 0",
               jump_e, imm, rd, rd_e);
    end
    @(negedge clk);
    send(32'h004100E7, 32'h304);
    #2;
    checks++;
    if (jump_e !== 1 || pc_e !== 0 || imm !== 32'd4) begin
      errors++;
      $display("FAIL jalr_fields: got jump=%b pc_e=%b imm=%h, required 1 0 00000004", jump_e, pc_e, imm);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] insts [4];
    logic [71:0] snap;
    int unsigned acc = 0;
    int unsigned guard = 0;
    int unsigned n0;
    insts[0] = 32'h00100093; insts[1] = 32'h00200113;
    insts[2] = 32'h00300193; insts[3] = 32'h00400213;
    snap = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_inst  = insts[acc];
      in_pc    = 32'h400 + 32'(4 * acc);
      #2;
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0 || acc !== 2) begin
          errors++;
          $display("FAIL bp_ready: got in_ready=%b accepted=%0d, required 0 2", in_ready, acc);
        end
      end
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1 || out_pc !== 32'h400 || (c == 2 && obs !== snap)) begin
          errors++;
          $display("FAIL bp_hold: got v=%b pc=%h bundle=%h, required 1 00000400 %h",
                   out_valid, out_pc, obs, (c == 2) ? snap : obs);
        end
        snap = obs;
      end
      if (in_ready) acc++;
      @(negedge clk);
    end
    n0 = n_out;
    out_ready = 1'b1;
    while ((acc < 4 || out_valid) && guard < 20) begin
      if (acc < 4) begin
        in_valid = 1'b1;
        in_inst  = insts[acc];
        in_pc    = 32'h400 + 32'(4 * acc);
      end else begin
        in_valid = 1'b0;
      end
      #2;
      if (acc < 4 && in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    #2;
    checks++;
    if (guard >= 20 || n_out - n0 !== 4) begin
      errors++;
      $display("FAIL bp_delivered: got %0d outputs in %0d cycles, required 4", n_out - n0, guard);
    end
  endtask

  task automatic test_flush();
    logic leak = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h00700293, 32'h500);
    send(32'h00800313, 32'h504);
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_prefull: got in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00900393;
    in_pc    = 32'h508;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    repeat (4) begin
      @(negedge clk);
      #2;
      leak = leak | out_valid;
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++; $display("FAIL flush_leak: got out_valid seen=%b, required 0", leak);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] vals [3];
    vals[0] = 32'h00000000; vals[1] = 32'hFFFFFFFF; vals[2] = 32'h40001033;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      send(vals[k], 32'h600 + 32'(4 * k));
      #2;
      checks++;
      if (out_valid !== 1 || illegal !== 1 ||
          {rd_e, rs1_e, rs2_e, imm_e, pc_e, jump_e, branch_e} !== 7'b0 ||
          imm !== 32'd0 || full_inst !== 17'd0) begin
        errors++;
        $display("FAIL illegal_%h: got v=%b ill=%b en=%b imm=%h fi=%h, required 1 1 0000000 00000000 00000",
                 vals[k], out_valid, illegal, {rd_e, rs1_e, rs2_e, imm_e, pc_e, jump_e, branch_e},
                 imm, full_inst);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int unsigned k;
    int unsigned guard = 0;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h67;
    ops[4] = 7'h73; ops[5] = 7'h0f; ops[6] = 7'h23; ops[7] = 7'h63;
    ops[8] = 7'h37; ops[9] = 7'h17; ops[10] = 7'h6f;
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k < 11) r[6:0] = ops[k];
      if (k == 0 && $urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = r;
      in_pc     = 32'h1000 + 32'(4 * c);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    checks++;
    if (guard >= 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending after %0d cycles, required 0", sb.size(), guard);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h00A00413, 32'h700);
    send(32'h00B00493, 32'h704);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_inst  = 32'h00500093;
    in_pc    = 32'h708;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || out_pc !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b bundle=%h pc=%h, required all 0", out_valid, obs, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_jump();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
